// File: rtl/axis_skid_buf.sv
// axis_skid_buf -- two-entry, fully registered AXI-Stream skid buffer.
// Carries tdata plus tlast. Every output (s_axis_tready and all m_axis_*)
// comes straight from a flop, so no combinational path crosses the stage,
// yet a beat per clock is sustained while m_axis_tready stays high.
//
// Optional build macro:
//   AXIS_SKID_BUF_ASSERT_EN  compiles in a simulation-only checker
//                            (axis_skid_buf_chk). It adds no logic to the
//                            synthesized datapath.

`ifdef AXIS_SKID_BUF_ASSERT_EN
// Protocol checker bound to the buffer's registered state.
module axis_skid_buf_chk #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] m_axis_tdata,
   input  logic                  m_axis_tvalid,
   input  logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   input  logic                  skid_valid
);
   logic                  hold_r;
   logic [DATA_WIDTH-1:0] hold_data_r;
   logic                  hold_last_r;

   // Remember the output beat whenever it is stalled, so the next edge can check it held.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         hold_r      <= 1'b0;
         hold_data_r <= {DATA_WIDTH{1'b0}};
         hold_last_r <= 1'b0;
      end else begin
         hold_r      <= m_axis_tvalid && !m_axis_tready;
         hold_data_r <= m_axis_tdata;
         hold_last_r <= m_axis_tlast;
      end
   end

   // Check stability, overflow and state consistency at every active edge.
   always @(posedge aclk) begin
      if (aresetn) begin
         if (hold_r) begin
            assert (m_axis_tvalid && (m_axis_tdata == hold_data_r) && (m_axis_tlast == hold_last_r))
               else $error("axis_skid_buf: output changed while stalled");
         end
         assert (!(s_axis_tvalid && s_axis_tready && skid_valid))
            else $error("axis_skid_buf: input accepted with skid full");
         assert (!(skid_valid && !m_axis_tvalid))
            else $error("axis_skid_buf: skid full while output empty");
      end
   end
endmodule
`endif

module axis_skid_buf #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready
);
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  out_last_r;
   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] skid_data_r;
   logic                  skid_last_r;
   logic                  skid_valid_r;
   logic                  ready_r;

   logic                  in_xfer_s;
   logic                  out_xfer_s;
   logic                  load_out_s;
   logic                  load_skid_s;
   logic                  skid_to_out_s;

   assign s_axis_tready = ready_r;
   assign m_axis_tdata  = out_data_r;
   assign m_axis_tvalid = out_valid_r;
   assign m_axis_tlast  = out_last_r;

   // Next-state and datapath steering from the occupancy state and the two handshakes.
   always_comb begin
      state_nxt_s   = state_r;
      load_out_s    = 1'b0;
      load_skid_s   = 1'b0;
      skid_to_out_s = 1'b0;
      in_xfer_s     = s_axis_tvalid && ready_r;
      out_xfer_s    = out_valid_r && m_axis_tready;
      case (state_r)
         ST_EMPTY: begin
            if (in_xfer_s) begin
               state_nxt_s = ST_ONE;
               load_out_s  = 1'b1;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (in_xfer_s && !out_xfer_s) begin
               // Downstream stalled: park the incoming beat in the skid slot.
               state_nxt_s = ST_TWO;
               load_skid_s = 1'b1;
            end else if (in_xfer_s && out_xfer_s) begin
               state_nxt_s = ST_ONE;
               load_out_s  = 1'b1;
            end else if (out_xfer_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_ONE;
            end
         end
         ST_TWO: begin
            // ready is low here, so only a drain can happen.
            if (out_xfer_s) begin
               state_nxt_s   = ST_ONE;
               skid_to_out_s = 1'b1;
            end else begin
               state_nxt_s = ST_TWO;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // State register plus the registered handshake/valid flags derived from the next state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r      <= ST_EMPTY;
         ready_r      <= 1'b0;
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         ready_r      <= (state_nxt_s != ST_TWO);
         out_valid_r  <= (state_nxt_s != ST_EMPTY);
         skid_valid_r <= (state_nxt_s == ST_TWO);
      end
   end

   // Output register: loads a fresh beat or the parked skid beat, otherwise holds.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_data_r <= {DATA_WIDTH{1'b0}};
         out_last_r <= 1'b0;
      end else if (load_out_s) begin
         out_data_r <= s_axis_tdata;
         out_last_r <= s_axis_tlast;
      end else if (skid_to_out_s) begin
         out_data_r <= skid_data_r;
         out_last_r <= skid_last_r;
      end else begin
         out_data_r <= out_data_r;
         out_last_r <= out_last_r;
      end
   end

   // Skid register: captures the beat that arrives while the output is stalled.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         skid_data_r <= {DATA_WIDTH{1'b0}};
         skid_last_r <= 1'b0;
      end else if (load_skid_s) begin
         skid_data_r <= s_axis_tdata;
         skid_last_r <= s_axis_tlast;
      end else begin
         skid_data_r <= skid_data_r;
         skid_last_r <= skid_last_r;
      end
   end

`ifdef AXIS_SKID_BUF_ASSERT_EN
   axis_skid_buf_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (ready_r),
      .m_axis_tdata  (out_data_r),
      .m_axis_tvalid (out_valid_r),
      .m_axis_tlast  (out_last_r),
      .m_axis_tready (m_axis_tready),
      .skid_valid    (skid_valid_r)
   );
`endif

endmodule

// File: tb/tb_axis_skid_buf.sv
// Testbench for axis_skid_buf: the reference model is a FIFO of accepted
// beats (the buffer's contents). Its length gives expected valid/ready,
// its head gives the expected output beat.
module tb_axis_skid_buf;
   localparam int DW = 16;

   logic          aclk;
   logic          aresetn;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;

   logic [DW:0]   exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   logic          armed;
   logic [DW-1:0] cur_data;
   logic          cur_last;
   bit            last_rand;
   int            accepted;

   axis_skid_buf #(.DATA_WIDTH(DW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_data),
      .s_axis_tvalid (s_valid),
      .s_axis_tlast  (s_last),
      .s_axis_tready (s_ready),
      .m_axis_tdata  (m_data),
      .m_axis_tvalid (m_valid),
      .m_axis_tlast  (m_last),
      .m_axis_tready (m_ready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ready comes up at the first rising edge seen with reset released.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) armed <= 1'b0;
      else          armed <= 1'b1;
   end

   // Monitor: compare outputs against the model at the falling edge, pop on output transfer.
   always @(negedge aclk) begin
      if (!aresetn) begin
         exp_q.delete();
         chk("rst_m_tvalid", 32'(m_valid), 32'd0);
         chk("rst_m_tdata",  32'(m_data),  32'd0);
         chk("rst_m_tlast",  32'(m_last),  32'd0);
         chk("rst_s_tready", 32'(s_ready), 32'd0);
      end else begin
         chk("s_tready", 32'(s_ready), 32'(armed && (exp_q.size() < 2)));
         chk("m_tvalid", 32'(m_valid), 32'(exp_q.size() > 0));
         if (m_valid && (exp_q.size() > 0)) begin
            chk("m_tdata", 32'(m_data), 32'(exp_q[0][DW-1:0]));
            chk("m_tlast", 32'(m_last), 32'(exp_q[0][DW]));
            if (m_ready) void'(exp_q.pop_front());
         end
      end
   end

   // One clock of stimulus; the accepted beat is pushed into the model after the monitor ran.
   task automatic step(input logic v, input logic mr);
      @(posedge aclk);
      #1;
      s_valid = v;
      s_data  = cur_data;
      s_last  = cur_last;
      m_ready = mr;
      @(negedge aclk);
      #1;
      if (aresetn && s_valid && s_ready) begin
         exp_q.push_back({s_last, s_data});
         accepted++;
         cur_data = cur_data + 16'd1;
         cur_last = last_rand ? ($urandom_range(0, 3) == 0) : (cur_data == 16'h0010);
      end
   endtask

   task automatic new_burst(input logic [DW-1:0] start, input bit rnd);
      cur_data  = start;
      last_rand = rnd;
      cur_last  = rnd ? ($urandom_range(0, 3) == 0) : (start == 16'h0010);
      accepted  = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b1;
      s_valid = 1'b0;
      s_data  = 16'h0000;
      s_last  = 1'b0;
      m_ready = 1'b0;
      new_burst(16'hDEAD, 1'b0);
      #1 aresetn = 1'b0;

      // Reset held with valid asserted: nothing is accepted.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      chk("rst_hold_empty", 32'(exp_q.size()), 32'd0);

      // Release, then stream 0x0001..0x0010 with last on 0x0010.
      new_burst(16'h0001, 1'b0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      for (int i = 0; (i < 40) && (accepted < 16); i++) step(1'b1, 1'b1);
      chk("stream_count", 32'(accepted), 32'd16);
      drain();

      // Single-cycle downstream stall in a continuous stream.
      new_burst(16'h0100, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      drain();

      // Ten-cycle stall: the buffer fills to exactly two beats.
      new_burst(16'h0200, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      chk("long_stall_fill", 32'(exp_q.size()), 32'd2);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      drain();

      // Random valid/ready, 1000 beats with random tlast.
      new_burst(16'h1000, 1'b1);
      for (int i = 0; (i < 8000) && (accepted < 1000); i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rand_beats", 32'(accepted >= 1000), 32'd1);
      drain();

      // Reset while full: outputs clear at once, old beats never reappear.
      new_burst(16'h2000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("pre_reset_fill", 32'(exp_q.size()), 32'd2);
      @(posedge aclk);
      #1 aresetn = 1'b0;
      #1;
      chk("async_m_tvalid", 32'(m_valid), 32'd0);
      chk("async_m_tdata",  32'(m_data),  32'd0);
      chk("async_m_tlast",  32'(m_last),  32'd0);
      chk("async_s_tready", 32'(s_ready), 32'd0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
      new_burst(16'h3000, 1'b0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      chk("post_reset_beats", 32'(accepted), 32'd5);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
